// File: rtl/traffic_request_conditioner.sv
// Input conditioning for the intersection controller: synchronizes and debounces raw
// pedestrian buttons and lane sensors, then latches requests until the matching light acks them.
module traffic_request_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned CNT_WIDTH       = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_straight_street_button,
   input  logic raw_cross_street_button,
   input  logic raw_straight_street_straight_lane_sensor,
   input  logic raw_straight_street_turn_lane_sensor,
   input  logic raw_cross_street_straight_lane_sensor,
   input  logic raw_cross_street_turn_lane_sensor,
   input  logic straight_street_walk_light,
   input  logic cross_street_walk_light,
   input  logic straight_street_straight_lane_green_light,
   input  logic straight_street_turn_lane_green_light,
   input  logic cross_street_straight_lane_green_light,
   input  logic cross_street_turn_lane_green_light,
   output logic straight_street_pedestrian_button,
   output logic cross_street_pedestrian_button,
   output logic straight_street_straight_lane_car_sensor,
   output logic straight_street_turn_lane_car_sensor,
   output logic cross_street_straight_lane_car_sensor,
   output logic cross_street_turn_lane_car_sensor
);

   localparam int unsigned N_CH  = 6;
   localparam int unsigned N_PED = 2;
   localparam int unsigned N_CAR = 4;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

   typedef enum logic {PED_IDLE, PED_PENDING} ped_state_t;
   typedef enum logic [1:0] {CAR_EMPTY, CAR_WAITING, CAR_SERVED} car_state_t;

   // Channel order: 0/1 pedestrian buttons, 2..5 lane sensors
   logic [N_CH-1:0]      w_raw;
   logic [N_CH-1:0]      w_ack;
   logic [N_CH-1:0]      r_sync1;
   logic [N_CH-1:0]      r_sync2;
   logic [N_CH-1:0]      r_deb;
   logic [CNT_WIDTH-1:0] r_cnt [N_CH];
   logic [N_CH-1:0]      w_rise;
   logic [N_CH-1:0]      w_fall;

   ped_state_t           r_ped_state [N_PED];
   logic [N_PED-1:0]     r_ped_out;
   car_state_t           r_car_state [N_CAR];
   logic [N_CAR-1:0]     r_car_out;
   logic [N_CAR-1:0]     w_car_rise;
   logic [N_CAR-1:0]     w_car_fall;
   logic [N_CAR-1:0]     w_car_ack;

   assign w_raw = {raw_cross_street_turn_lane_sensor, raw_cross_street_straight_lane_sensor,
                   raw_straight_street_turn_lane_sensor, raw_straight_street_straight_lane_sensor,
                   raw_cross_street_button, raw_straight_street_button};
   assign w_ack = {cross_street_turn_lane_green_light, cross_street_straight_lane_green_light,
                   straight_street_turn_lane_green_light, straight_street_straight_lane_green_light,
                   cross_street_walk_light, straight_street_walk_light};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Counter runs only while the sample disagrees with the accepted level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_deb <= '0;
         for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_deb[i] <= ~r_deb[i];
               r_cnt[i] <= '0;
            end else if (r_cnt[i] != CNT_MAX) begin
               r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
            end
         end
      end
   end

   // Flip strobes coincide with the edge on which the debounced level changes
   always_comb begin
      w_rise = '0;
      w_fall = '0;
      for (int i = 0; i < N_CH; i++) begin
         if ((r_sync2[i] != r_deb[i]) && (r_cnt[i] == CNT_LAST)) begin
            w_rise[i] = ~r_deb[i];
            w_fall[i] = r_deb[i];
         end
      end
   end

   assign w_car_rise = w_rise[N_CH-1:N_PED];
   assign w_car_fall = w_fall[N_CH-1:N_PED];
   assign w_car_ack  = w_ack[N_CH-1:N_PED];

   // Pedestrian latch: an ack in the same cycle as a press suppresses it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ped_out <= '0;
         for (int p = 0; p < N_PED; p++) r_ped_state[p] <= PED_IDLE;
      end else begin
         for (int p = 0; p < N_PED; p++) begin
            case (r_ped_state[p])
               PED_IDLE: begin
                  if (w_rise[p] && !w_ack[p]) begin
                     r_ped_state[p] <= PED_PENDING;
                     r_ped_out[p]   <= 1'b1;
                  end
               end
               PED_PENDING: begin
                  if (w_ack[p]) begin
                     r_ped_state[p] <= PED_IDLE;
                     r_ped_out[p]   <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

   // Car request: a departing car outranks a simultaneous green
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_car_out <= '0;
         for (int c = 0; c < N_CAR; c++) r_car_state[c] <= CAR_EMPTY;
      end else begin
         for (int c = 0; c < N_CAR; c++) begin
            case (r_car_state[c])
               CAR_EMPTY: begin
                  if (w_car_rise[c]) begin
                     if (w_car_ack[c]) begin
                        r_car_state[c] <= CAR_SERVED;
                        r_car_out[c]   <= 1'b0;
                     end else begin
                        r_car_state[c] <= CAR_WAITING;
                        r_car_out[c]   <= 1'b1;
                     end
                  end
               end
               CAR_WAITING: begin
                  if (w_car_fall[c]) begin
                     r_car_state[c] <= CAR_EMPTY;
                     r_car_out[c]   <= 1'b0;
                  end else if (w_car_ack[c]) begin
                     r_car_state[c] <= CAR_SERVED;
                     r_car_out[c]   <= 1'b0;
                  end
               end
               CAR_SERVED: begin
                  if (w_car_fall[c]) begin
                     r_car_state[c] <= CAR_EMPTY;
                     r_car_out[c]   <= 1'b0;
                  end else if (!w_car_ack[c]) begin
                     r_car_state[c] <= CAR_WAITING;
                     r_car_out[c]   <= 1'b1;
                  end
               end
               default: begin
                  r_car_state[c] <= CAR_EMPTY;
                  r_car_out[c]   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign straight_street_pedestrian_button       = r_ped_out[0];
   assign cross_street_pedestrian_button          = r_ped_out[1];
   assign straight_street_straight_lane_car_sensor = r_car_out[0];
   assign straight_street_turn_lane_car_sensor     = r_car_out[1];
   assign cross_street_straight_lane_car_sensor    = r_car_out[2];
   assign cross_street_turn_lane_car_sensor        = r_car_out[3];

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Scoreboard bench for traffic_request_conditioner: stimulus queues edge-tagged expectations,
// a negedge monitor pops and compares them against the six outputs.
`timescale 1ns/1ps
module tb_traffic_request_conditioner;

   logic clk;
   logic rst_n;
   logic raw_ss_btn, raw_cs_btn, raw_ss_sl, raw_ss_tl, raw_cs_sl, raw_cs_tl;
   logic ss_walk, cs_walk, ss_sl_g, ss_tl_g, cs_sl_g, cs_tl_g;
   logic ss_ped, cs_ped, ss_sl, ss_tl, cs_sl, cs_tl;

   typedef struct {
      int unsigned at_edge;
      logic [5:0]  mask;
      logic [5:0]  exp;
      string       name;
   } sb_entry_t;

   sb_entry_t   sb[$];
   int unsigned g_edge;
   int          checks;
   int          failures;
   logic [5:0]  got;

   traffic_request_conditioner #(.DEBOUNCE_CYCLES(16), .CNT_WIDTH(5)) dut (
      .clk                                       (clk),
      .rst_n                                     (rst_n),
      .raw_straight_street_button                (raw_ss_btn),
      .raw_cross_street_button                   (raw_cs_btn),
      .raw_straight_street_straight_lane_sensor  (raw_ss_sl),
      .raw_straight_street_turn_lane_sensor      (raw_ss_tl),
      .raw_cross_street_straight_lane_sensor     (raw_cs_sl),
      .raw_cross_street_turn_lane_sensor         (raw_cs_tl),
      .straight_street_walk_light                (ss_walk),
      .cross_street_walk_light                   (cs_walk),
      .straight_street_straight_lane_green_light (ss_sl_g),
      .straight_street_turn_lane_green_light     (ss_tl_g),
      .cross_street_straight_lane_green_light    (cs_sl_g),
      .cross_street_turn_lane_green_light        (cs_tl_g),
      .straight_street_pedestrian_button         (ss_ped),
      .cross_street_pedestrian_button            (cs_ped),
      .straight_street_straight_lane_car_sensor  (ss_sl),
      .straight_street_turn_lane_car_sensor      (ss_tl),
      .cross_street_straight_lane_car_sensor     (cs_sl),
      .cross_street_turn_lane_car_sensor         (cs_tl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial g_edge = 0;
   always @(posedge clk) g_edge <= g_edge + 1;

   assign got = {ss_ped, cs_ped, ss_sl, ss_tl, cs_sl, cs_tl};

   // Monitor: compare entries tagged with the edge just passed; stale entries are misses
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].at_edge <= g_edge) begin
         checks++;
         if (sb[0].at_edge < g_edge) begin
            failures++;
            $display("FAIL %s: entry for edge %0d not sampled (now edge %0d)",
                     sb[0].name, sb[0].at_edge, g_edge);
         end else if ((got & sb[0].mask) !== (sb[0].exp & sb[0].mask)) begin
            failures++;
            $display("FAIL %s @edge %0d: got %b required %b (mask %b)",
                     sb[0].name, g_edge, got & sb[0].mask, sb[0].exp & sb[0].mask, sb[0].mask);
         end
         void'(sb.pop_front());
      end
   end

   task automatic expect_at(input int unsigned e, input logic [5:0] m, input logic [5:0] v,
                            input string nm);
      sb_entry_t t;
      t.at_edge = e; t.mask = m; t.exp = v; t.name = nm;
      sb.push_back(t);
   endtask

   task automatic step_to(input int unsigned e);
      while (g_edge < e) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_inputs();
      raw_ss_btn = 0; raw_cs_btn = 0; raw_ss_sl = 0; raw_ss_tl = 0; raw_cs_sl = 0; raw_cs_tl = 0;
      ss_walk = 0; cs_walk = 0; ss_sl_g = 0; ss_tl_g = 0; cs_sl_g = 0; cs_tl_g = 0;
   endtask

   task automatic do_reset(output int unsigned base);
      rst_n = 1'b0;
      clear_inputs();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      base = g_edge;
   endtask

   initial begin
      int unsigned b;
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      clear_inputs();

      // Reset state
      do_reset(b);
      expect_at(b + 1, 6'h3F, 6'h00, "reset_state");
      expect_at(b + 3, 6'h3F, 6'h00, "reset_state_idle");
      step_to(b + 5);

      // Held press latches at +18, survives release, cleared by walk at +60
      do_reset(b);
      expect_at(b + 17, 6'h30, 6'h00, "ped_before_debounce");
      expect_at(b + 18, 6'h30, 6'h20, "ped_latch_edge18");
      expect_at(b + 45, 6'h30, 6'h20, "ped_held_after_release");
      expect_at(b + 59, 6'h30, 6'h20, "ped_pending_before_walk");
      expect_at(b + 60, 6'h30, 6'h00, "ped_ack_edge60");
      expect_at(b + 62, 6'h30, 6'h00, "ped_idle_after_ack");
      raw_ss_btn = 1;
      step_to(b + 40); raw_ss_btn = 0;
      step_to(b + 59); ss_walk = 1;
      step_to(b + 60); ss_walk = 0;
      step_to(b + 64);

      // Bounce every 5 cycles never asserts; steady level asserts 18 edges after last change
      do_reset(b);
      for (int k = 0; k < 12; k++) expect_at(b + 3 + 10 * k, 6'h30, 6'h00, "bounce_no_request");
      expect_at(b + 117, 6'h30, 6'h00, "bounce_settle_edge17");
      expect_at(b + 118, 6'h30, 6'h20, "bounce_settle_edge18");
      for (int k = 0; k < 20; k++) begin
         step_to(b + 5 * k);
         raw_ss_btn = ((k % 2) == 0);
      end
      step_to(b + 100); raw_ss_btn = 1;
      step_to(b + 120);

      // Press during walk is ignored and not queued
      do_reset(b);
      expect_at(b + 18, 6'h30, 6'h00, "walk_press_ignored_rise");
      expect_at(b + 19, 6'h30, 6'h00, "walk_press_ignored_after");
      expect_at(b + 30, 6'h30, 6'h00, "walk_press_ignored_mid");
      expect_at(b + 40, 6'h30, 6'h00, "walk_press_not_queued");
      expect_at(b + 60, 6'h30, 6'h00, "walk_press_final");
      raw_ss_btn = 1; ss_walk = 1;
      step_to(b + 30); ss_walk = 0;
      step_to(b + 31); raw_ss_btn = 0;
      step_to(b + 62);

      // Car channel: request, served by green, missed phase re-request, car leaves
      do_reset(b);
      expect_at(b + 17, 6'h0F, 6'h00, "car_before_debounce");
      expect_at(b + 18, 6'h0F, 6'h01, "car_waiting_edge18");
      expect_at(b + 29, 6'h0F, 6'h01, "car_waiting_before_green");
      expect_at(b + 30, 6'h0F, 6'h00, "car_served_edge30");
      expect_at(b + 50, 6'h0F, 6'h00, "car_served_green_high");
      expect_at(b + 51, 6'h0F, 6'h01, "car_rerequest_edge51");
      expect_at(b + 77, 6'h0F, 6'h01, "car_still_waiting");
      expect_at(b + 78, 6'h0F, 6'h00, "car_left_edge78");
      raw_cs_tl = 1;
      step_to(b + 29); cs_tl_g = 1;
      step_to(b + 50); cs_tl_g = 0;
      step_to(b + 60); raw_cs_tl = 0;
      step_to(b + 80);

      // Asynchronous reset mid-request clears all outputs; requests return 18 edges later
      do_reset(b);
      expect_at(b + 18, 6'h3F, 6'h3F, "all_requests_up");
      expect_at(b + 24, 6'h3F, 6'h3F, "all_requests_held");
      expect_at(b + 25, 6'h3F, 6'h00, "async_reset_clears");
      expect_at(b + 30, 6'h3F, 6'h00, "reset_rearm_debounce");
      expect_at(b + 42, 6'h3F, 6'h00, "reset_rearm_edge17");
      expect_at(b + 43, 6'h3F, 6'h3F, "reset_rearm_edge18");
      raw_ss_btn = 1; raw_cs_btn = 1;
      raw_ss_sl = 1; raw_ss_tl = 1; raw_cs_sl = 1; raw_cs_tl = 1;
      step_to(b + 25);
      #3 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      step_to(b + 45);

      // Ack coincident with debounced rise wins; a fresh press is needed afterwards
      do_reset(b);
      expect_at(b + 17, 6'h30, 6'h00, "ack_rise_before");
      expect_at(b + 18, 6'h30, 6'h00, "ack_rise_same_edge");
      expect_at(b + 19, 6'h30, 6'h00, "ack_rise_after");
      expect_at(b + 30, 6'h30, 6'h00, "ack_rise_held_button");
      expect_at(b + 77, 6'h30, 6'h00, "new_press_before");
      expect_at(b + 78, 6'h30, 6'h20, "new_press_latches");
      raw_ss_btn = 1;
      step_to(b + 17); ss_walk = 1;
      step_to(b + 18); ss_walk = 0;
      step_to(b + 30); raw_ss_btn = 0;
      step_to(b + 60); raw_ss_btn = 1;
      step_to(b + 82);

      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/traffic_request_conditioner.md
Name: traffic_request_conditioner

Overview:
Input-side front end for the intersection controller. It takes raw, asynchronous, bouncy pedestrian buttons and lane car sensors and produces the clean request levels that the controller consumes as its pedestrian-button and car-sensor inputs. Pedestrian presses are latched until the controller services them, signalled by the matching walk light. Car requests are debounced presence, held until the lane's green light acknowledges them.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples needed to accept a level change (valid range 2..(2^CNT_WIDTH)-1).
CNT_WIDTH, 5, width of each per-channel debounce counter.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
raw_straight_street_button  input  1  raw main-street pedestrian button, async
raw_cross_street_button  input  1  raw cross-street pedestrian button, async
raw_straight_street_straight_lane_sensor  input  1  raw loop sensor, async
raw_straight_street_turn_lane_sensor  input  1  raw loop sensor, async
raw_cross_street_straight_lane_sensor  input  1  raw loop sensor, async
raw_cross_street_turn_lane_sensor  input  1  raw loop sensor, async
straight_street_walk_light  input  1  ack for main-street pedestrian request
cross_street_walk_light  input  1  ack for cross-street pedestrian request
straight_street_straight_lane_green_light  input  1  ack for that lane's car request
straight_street_turn_lane_green_light  input  1  ack
cross_street_straight_lane_green_light  input  1  ack
cross_street_turn_lane_green_light  input  1  ack
straight_street_pedestrian_button  output  1  latched pedestrian request to controller
cross_street_pedestrian_button  output  1  latched pedestrian request
straight_street_straight_lane_car_sensor  output  1  conditioned car request
straight_street_turn_lane_car_sensor  output  1  conditioned car request
cross_street_straight_lane_car_sensor  output  1  conditioned car request
cross_street_turn_lane_car_sensor  output  1  conditioned car request

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; synchronizer flops, debounced levels, counters and latches 0. Takes effect immediately even mid-debounce or with a request pending. The first sample is taken on the first clk edge after release.
- Per raw input, all six channels identical:
  - 2-flop synchronizer, then debounce.
  - Counter resets to 0 whenever the synchronized sample equals the current debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and the sample still differs, the debounced level flips on that edge and the counter returns to 0.
  - Total latency from a clean raw edge to the debounced flip is 2 + DEBOUNCE_CYCLES clk edges.
  - The counter saturates and never wraps.
- Pedestrian channel, 2 states: IDLE and PENDING.
  - IDLE -> PENDING on a debounced rising edge while the walk light is 0. Output goes 1 on the same edge the debounced level rises.
  - PENDING -> IDLE on the first edge the walk light is sampled 1. Output goes 0 on that edge.
  - Press while the walk light is 1: ignored and not queued.
  - Ack and debounced rising edge in the same cycle: ack wins; the channel ends in IDLE.
  - Holding the button produces one request only; a release (debounced) is needed before a new one.
  - A button release does not cancel a PENDING request.
- Car channel, 3 states: EMPTY, WAITING, SERVED.
  - EMPTY -> WAITING on a debounced rising presence edge. Output is 1 in WAITING.
  - WAITING -> SERVED when the lane green is sampled 1. Output is 0 in SERVED, so the controller does not re-request for a car already being served.
  - SERVED -> EMPTY when debounced presence falls.
  - SERVED -> WAITING when green falls while presence is still 1 (car missed the phase).
  - WAITING -> EMPTY when debounced presence falls before green, i.e. the car left.
  - Green high and presence rising in the same cycle: go directly to SERVED; output stays 0.
- Outputs are registered, with no combinational path from any input to any output.

Test Plan:
- DEBOUNCE_CYCLES=16; raw_straight_street_button held 1 from cycle 0 -> straight_street_pedestrian_button rises at edge 18 and stays 1 after the button is released at cycle 40; walk light pulsed 1 at cycle 60 -> output 0 at edge 60, cross output stays 0 throughout.
- Raw button toggling every 5 cycles for 100 cycles (bounce) -> output never asserts; then held 1 -> output asserts exactly 18 edges after the last transition.
- Walk light held 1 while button pressed for 30 cycles, then walk drops, button released -> no request is ever latched (output stays 0).
- raw_cross_street_turn_lane_sensor held 1 -> output 1 at edge 18; green 1 at cycle 30 -> output 0 at 30; green drops at 50 with sensor still 1 -> output 1 at 51; sensor drops -> output 0 at 18 edges later.
- Pending pedestrian and car requests, rst_n pulsed low for 1 ns between edges -> all six outputs 0 immediately; with inputs held high, they reassert 18 edges after rst_n release.
- Ack asserted on the same edge the debounced button rises -> output remains 0 on that and all following edges until a new press.
